// File: rtl/reg_file_wb_if.sv
// Register-file bus: two operand read ports, one debug read port, one write port.
// Latency: reads are combinational; a write lands on the clk edge where we=1.
// Backpressure: none; the write port is sampled every edge and never stalls.
//
// Modports:
//   master - datapath/monitor side: drives addresses and write data, receives read data
//   slave  - register file side: receives addresses and write data, drives read data
interface reg_file_wb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] ra0;     // rs1 read address
  logic [WIDTH-1:0]  rd0;     // rs1 read data
  logic [ADDR_W-1:0] ra1;     // rs2 read address
  logic [WIDTH-1:0]  rd1;     // rs2 read data
  logic              we;      // RegWrite
  logic [ADDR_W-1:0] wa;      // rd field
  logic [WIDTH-1:0]  wd;      // write-back select output
  logic [ADDR_W-1:0] dbg_ra;  // board monitor read address
  logic [WIDTH-1:0]  dbg_rd;  // board monitor read data

  modport master (
    output ra0, ra1, we, wa, wd, dbg_ra,
    input  rd0, rd1, dbg_rd
  );

  modport slave (
    input  ra0, ra1, we, wa, wd, dbg_ra,
    output rd0, rd1, dbg_rd
  );

endinterface

// File: rtl/reg_file_wb.sv
// Register file behind the write-back select: 2 operand reads + 1 debug read, entry 0 reads zero.
// Latency: 0-cycle combinational reads; writes visible the cycle after the write edge.
// Backpressure: none; every edge with we=1 and wa!=0 commits, last write wins.
//
// Ports:
//   clk - system clock, writes on rising edge
//   rst - asynchronous active-high reset; clears every entry and forces all reads to 0
//   bus - reg_file_wb_if.slave: ra0/rd0, ra1/rd1, we/wa/wd, dbg_ra/dbg_rd
//
// Optional build macro REG_FILE_WB_BYPASS_EN: when defined, rd0/rd1 forward wd in the
// same cycle when the port address matches a pending write (never for address 0, never
// for dbg_rd). Storage behaviour is identical with and without the macro.
module reg_file_wb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 has no storage; the array starts at index 1.
  logic [WIDTH-1:0] mem [1:DEPTH-1];

  // A write is real only outside reset and to a non-zero address.
  logic wr_en;
  assign wr_en = !rst && bus.we && (bus.wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Stored values per read port; address 0 never touches the array.
  logic [WIDTH-1:0] stored0;
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored_dbg;

  assign stored0    = (bus.ra0    == '0) ? '0 : mem[bus.ra0];
  assign stored1    = (bus.ra1    == '0) ? '0 : mem[bus.ra1];
  assign stored_dbg = (bus.dbg_ra == '0) ? '0 : mem[bus.dbg_ra];

  // Operand ports, optionally write-through. wr_en already excludes wa=0, so an
  // address match here can never forward onto a port reading x0.
  logic [WIDTH-1:0] op0;
  logic [WIDTH-1:0] op1;

`ifdef REG_FILE_WB_BYPASS_EN
  logic hit0;
  logic hit1;
  assign hit0 = wr_en && (bus.wa == bus.ra0);
  assign hit1 = wr_en && (bus.wa == bus.ra1);
  assign op0  = hit0 ? bus.wd : stored0;
  assign op1  = hit1 ? bus.wd : stored1;
`else
  assign op0  = stored0;
  assign op1  = stored1;
`endif

  // Reset clears the array asynchronously, but the explicit gate keeps the outputs
  // at zero in the same delta the reset rises, independent of the array update.
  assign bus.rd0    = rst ? '0 : op0;
  assign bus.rd1    = rst ? '0 : op1;
  assign bus.dbg_rd = rst ? '0 : stored_dbg;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
// Inputs change on the falling edge; outputs are sampled 1 ns after changes/rising edges.
// Expected values are hand-computed constants or derived from the write index.
module tb_reg_file_wb;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

`ifdef REG_FILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  reg_file_wb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  reg_file_wb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic chk_dat(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [ADDR_W-1:0] ad);
    bus.ra0    = a0;
    bus.ra1    = a1;
    bus.dbg_ra = ad;
  endtask

  // Single write on the next rising edge, driven from the falling edge.
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst    = 1'b1;
    bus.we = 1'b0;
    bus.wa = '0;
    bus.wd = '0;
    set_rd('0, '0, '0);

    // ---- reset: all ports read 0 for every address
    #2;
    for (int i = 0; i < 32; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(31 - i), ADDR_W'(i));
      #1;
      chk_dat("rst_rd0", bus.rd0, '0);
      chk_dat("rst_rd1", bus.rd1, '0);
      chk_dat("rst_dbg", bus.dbg_rd, '0);
    end

    // write attempted during reset is ignored
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = 5'd5;
    bus.wd = 32'hDEADBEEF;
    set_rd(5'd5, 5'd5, 5'd5);
    @(posedge clk);
    #1;
    chk_dat("rst_wr_rd0", bus.rd0, '0);
    @(negedge clk);
    bus.we = 1'b0;
    rst    = 1'b0;
    #1;
    chk_dat("rel_x5_rd0", bus.rd0, '0);
    chk_dat("rel_x5_dbg", bus.dbg_rd, '0);

    // ---- basic write/read
    wr(5'd3,  32'h12345678);
    wr(5'd31, 32'hCAFEF00D);
    set_rd(5'd3, 5'd31, 5'd31);
    #1;
    chk_dat("x3_rd0",  bus.rd0, 32'h12345678);
    chk_dat("x31_rd1", bus.rd1, 32'hCAFEF00D);
    chk_dat("x31_dbg", bus.dbg_rd, 32'hCAFEF00D);

    // same-address reads agree
    set_rd(5'd31, 5'd31, 5'd3);
    #1;
    chk_dat("same_rd0", bus.rd0, 32'hCAFEF00D);
    chk_dat("same_rd1", bus.rd1, 32'hCAFEF00D);
    chk_dat("x3_dbg",   bus.dbg_rd, 32'h12345678);

    // ---- x0 protection (also exercises "no bypass on address 0")
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = 5'd0;
    bus.wd = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0, 5'd0);
    #1;
    chk_dat("x0_pre_rd0", bus.rd0, '0);
    chk_dat("x0_pre_rd1", bus.rd1, '0);
    chk_dat("x0_pre_dbg", bus.dbg_rd, '0);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    chk_dat("x0_post_rd0", bus.rd0, '0);
    chk_dat("x0_post_rd1", bus.rd1, '0);
    chk_dat("x0_post_dbg", bus.dbg_rd, '0);
    @(posedge clk);
    #1;
    chk_dat("x0_later_rd0", bus.rd0, '0);

    // ---- bypass behaviour
    wr(5'd7, 32'h11);
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = 5'd7;
    bus.wd = 32'h22;
    set_rd(5'd7, 5'd7, 5'd7);
    #1;
    chk_dat("byp_rd0", bus.rd0, BYP ? 32'h22 : 32'h11);
    chk_dat("byp_rd1", bus.rd1, BYP ? 32'h22 : 32'h11);
    chk_dat("byp_dbg", bus.dbg_rd, 32'h11);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    chk_dat("byp_post_rd0", bus.rd0, 32'h22);
    chk_dat("byp_post_rd1", bus.rd1, 32'h22);
    chk_dat("byp_post_dbg", bus.dbg_rd, 32'h22);

    // ---- back-to-back writes to x10
    set_rd(5'd10, 5'd3, 5'd10);
    @(negedge clk);
    bus.we = 1'b1;
    bus.wa = 5'd10;
    bus.wd = 32'hA;
    @(posedge clk);
    #1;
    chk_dat("b2b_a_rd0", bus.rd0, 32'hA);
    chk_dat("b2b_a_dbg", bus.dbg_rd, 32'hA);
    bus.wd = 32'hB;
    @(posedge clk);
    #1;
    chk_dat("b2b_b_rd0", bus.rd0, 32'hB);
    chk_dat("b2b_b_dbg", bus.dbg_rd, 32'hB);
    bus.wd = 32'hC;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    chk_dat("b2b_c_rd0", bus.rd0, 32'hC);
    chk_dat("b2b_c_dbg", bus.dbg_rd, 32'hC);
    chk_dat("b2b_x3_rd1", bus.rd1, 32'h12345678);

    // ---- fill x1..x31 with their index, check, then async reset mid-cycle
    for (int i = 1; i < 32; i++) begin
      wr(ADDR_W'(i), WIDTH'(i));
    end
    for (int i = 0; i < 32; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(31 - i), ADDR_W'(i));
      #1;
      chk_dat("fill_rd0", bus.rd0, WIDTH'(i));
      chk_dat("fill_rd1", bus.rd1, WIDTH'(31 - i));
      chk_dat("fill_dbg", bus.dbg_rd, WIDTH'(i));
    end

    @(negedge clk);
    set_rd(5'd17, 5'd31, 5'd1);
    #1;
    chk_dat("pre_arst_rd0", bus.rd0, 32'd17);
    #1;
    rst = 1'b1;
    #1;
    chk_dat("arst_rd0", bus.rd0, '0);
    chk_dat("arst_rd1", bus.rd1, '0);
    chk_dat("arst_dbg", bus.dbg_rd, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(i), ADDR_W'(i));
      #1;
      chk_dat("post_arst_rd0", bus.rd0, '0);
      chk_dat("post_arst_rd1", bus.rd1, '0);
      chk_dat("post_arst_dbg", bus.dbg_rd, '0);
    end

    // first write after reset release takes effect
    wr(5'd9, 32'h5A5A5A5A);
    set_rd(5'd9, 5'd0, 5'd9);
    #1;
    chk_dat("post_rel_wr_rd0", bus.rd0, 32'h5A5A5A5A);
    chk_dat("post_rel_wr_dbg", bus.dbg_rd, 32'h5A5A5A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
